// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: result = op1 - op2 (mod 2^WIDTH),
//   one bit per clock, LSB first. The subtraction is done as op1 + ~op2 + 1:
//   the carry is seeded with 1 and the subtrahend bits are inverted on the fly.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while idle
//   op1     minuend, captured on the accepting edge
//   op2     subtrahend, captured on the accepting edge
//   busy    high while bits are being processed (WIDTH cycles)
//   done    one-cycle pulse after the last bit; result/flags valid from then on
//   result  op1 - op2 of the last completed operation
//   ofFlag  signed overflow of the last completed operation
//   borrow  unsigned borrow (op1 < op2) of the last completed operation
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ofFlag,
   output logic             borrow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;      // partial result, filled from the MSB end
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             sign1_q, sign1_d;
   logic             sign2_q, sign2_d;
   logic             of_q, of_d;
   logic             borrow_q, borrow_d;

   // One full-adder slice on the current LSBs, subtrahend inverted.
   logic nb, sum, cout;
   assign nb   = ~b_q[0];
   assign sum  = a_q[0] ^ nb ^ carry_q;
   assign cout = (a_q[0] & nb) | (a_q[0] & carry_q) | (nb & carry_q);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      sign1_d  = sign1_q;
      sign2_d  = sign2_q;
      of_d     = of_q;
      borrow_d = borrow_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = op1;
               b_d     = op2;
               sign1_d = op1[WIDTH-1];
               sign2_d = op2[WIDTH-1];
               carry_d = 1'b1;           // the +1 of the two's complement of op2
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = cout;
            acc_d   = {sum, acc_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Last bit: sum is the result MSB, cout the final carry-out.
               result_d = acc_d;
               borrow_d = ~cout;
               of_d     = (sign1_q != sign2_q) && (sum != sign1_q);
               cnt_d    = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;                // start is not looked at here
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         of_q     <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         of_q     <= of_d;
         borrow_q <= borrow_d;
      end
   end

   // busy/done decode straight from the state register, so both clear
   // the instant reset is asserted.
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign ofFlag = of_q;
   assign borrow = borrow_q;

endmodule
